// File: rtl/mc_control_unit_pkg.sv
// Shared encodings for the TinyV multicycle controller: opcodes, ALU codes,
// datapath select values, FSM states and the packed control-word layout.
package mc_control_unit_pkg;

  localparam int OPCODE_WIDTH = 6;
  localparam int ALU_SEL_SIZE = 4;

  localparam logic [ALU_SEL_SIZE-1:0] ALU_ADD   = 4'd0;
  localparam logic [ALU_SEL_SIZE-1:0] ALU_SUB   = 4'd1;
  localparam logic [ALU_SEL_SIZE-1:0] ALU_AND   = 4'd2;
  localparam logic [ALU_SEL_SIZE-1:0] ALU_OR    = 4'd3;
  localparam logic [ALU_SEL_SIZE-1:0] ALU_SLT   = 4'd4;
  localparam logic [ALU_SEL_SIZE-1:0] ALU_EQ    = 4'd5;
  localparam logic [ALU_SEL_SIZE-1:0] ALU_PASSA = 4'd6;

  localparam logic [OPCODE_WIDTH-1:0] OP_ADD  = 6'h01;
  localparam logic [OPCODE_WIDTH-1:0] OP_SUB  = 6'h02;
  localparam logic [OPCODE_WIDTH-1:0] OP_AND  = 6'h03;
  localparam logic [OPCODE_WIDTH-1:0] OP_OR   = 6'h04;
  localparam logic [OPCODE_WIDTH-1:0] OP_SLT  = 6'h05;
  localparam logic [OPCODE_WIDTH-1:0] OP_ADDI = 6'h11;
  localparam logic [OPCODE_WIDTH-1:0] OP_LW   = 6'h20;
  localparam logic [OPCODE_WIDTH-1:0] OP_SW   = 6'h21;
  localparam logic [OPCODE_WIDTH-1:0] OP_BEQ  = 6'h30;
  localparam logic [OPCODE_WIDTH-1:0] OP_JMP  = 6'h31;
  localparam logic [OPCODE_WIDTH-1:0] OP_JAL  = 6'h32;
  localparam logic [OPCODE_WIDTH-1:0] OP_HALT = 6'h3F;

  localparam logic [1:0] PCSEL_ALU  = 2'b00;
  localparam logic [1:0] PCSEL_D    = 2'b01;
  localparam logic [1:0] PCSEL_JUMP = 2'b10;

  localparam logic [1:0] ALUB_B    = 2'b00;
  localparam logic [1:0] ALUB_FOUR = 2'b01;
  localparam logic [1:0] ALUB_IMM  = 2'b10;

  localparam logic [1:0] REGW_IR21 = 2'b00;
  localparam logic [1:0] REGW_IR26 = 2'b01;
  localparam logic [1:0] REGW_R31  = 2'b10;

  typedef enum logic [3:0] {
    ST_FETCH, ST_DEC0, ST_DEC1, ST_EXEC_R, ST_WB_R, ST_EXEC_I, ST_WB_I,
    ST_MEM_ADDR, ST_MEM_RD, ST_MEM_WB, ST_MEM_WR, ST_BRANCH, ST_JUMP,
    ST_JAL_LINK, ST_JAL_WB, ST_HALT
  } ctrl_state_t;

  typedef enum logic [2:0] {
    CLS_R, CLS_ADDI, CLS_LW, CLS_SW, CLS_BEQ, CLS_JMP, CLS_JAL, CLS_HALT
  } instr_class_t;

  typedef struct packed {
    logic [1:0]              pc_wr_sel;
    logic                    pc_ctrl;
    logic                    mem_adr_sel;
    logic                    mem_wr_ctl;
    logic [ALU_SEL_SIZE-1:0] alu_op;
    logic                    alu_a_sel;
    logic [1:0]              alu_b_sel;
    logic                    reg_w_ctl;
    logic                    reg_data_sel;
    logic [1:0]              reg_w_sel;
    logic                    ir_wr;
    logic                    retire;
  } ctrl_out_t;

endpackage

// File: rtl/mc_control_unit_decode.sv
// Opcode decoder: instruction class, R-type ALU operation and illegal flag.
module ctrl_decode
  import mc_control_unit_pkg::*;
(
  input  logic [OPCODE_WIDTH-1:0] codop,
  output instr_class_t            instr_class,
  output logic [ALU_SEL_SIZE-1:0] alu_op,
  output logic                    illegal
);

  always_comb begin
    instr_class = CLS_HALT;
    alu_op      = ALU_ADD;
    illegal     = 1'b0;
    case (codop)
      OP_ADD:  begin instr_class = CLS_R; alu_op = ALU_ADD; end
      OP_SUB:  begin instr_class = CLS_R; alu_op = ALU_SUB; end
      OP_AND:  begin instr_class = CLS_R; alu_op = ALU_AND; end
      OP_OR:   begin instr_class = CLS_R; alu_op = ALU_OR;  end
      OP_SLT:  begin instr_class = CLS_R; alu_op = ALU_SLT; end
      OP_ADDI: instr_class = CLS_ADDI;
      OP_LW:   instr_class = CLS_LW;
      OP_SW:   instr_class = CLS_SW;
      OP_BEQ:  instr_class = CLS_BEQ;
      OP_JMP:  instr_class = CLS_JMP;
      OP_JAL:  instr_class = CLS_JAL;
      OP_HALT: instr_class = CLS_HALT;
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/mc_control_unit.sv
// Multicycle Moore controller for the TinyV datapath, with sticky halt/illegal
// status and a retired-instruction counter.
module mc_control_unit
  import mc_control_unit_pkg::*;
#(
  parameter int CNT_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [OPCODE_WIDTH-1:0] codop,
  output logic [1:0]              pcWrSel,
  output logic                    pcCtrl,
  output logic                    memAdrSel,
  output logic                    memWrCtl,
  output logic [ALU_SEL_SIZE-1:0] aluOp,
  output logic                    aluASel,
  output logic [1:0]              aluBSel,
  output logic                    regWCtl,
  output logic                    regDataSel,
  output logic [1:0]              regWSel,
  output logic                    irWr,
  output logic                    halted,
  output logic                    illegal_op,
  output logic                    retire,
  output logic [CNT_WIDTH-1:0]    instr_count
);

  ctrl_state_t            state_reg, state_next;
  logic                   halted_reg, illegal_reg, halt_retired_reg;
  logic [CNT_WIDTH-1:0]   instr_count_reg;
  instr_class_t           dec_class;
  logic [ALU_SEL_SIZE-1:0] dec_alu_op;
  logic                   dec_illegal;
  ctrl_out_t              ctl;

  ctrl_decode u_decode (
    .codop       (codop),
    .instr_class (dec_class),
    .alu_op      (dec_alu_op),
    .illegal     (dec_illegal)
  );

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_FETCH: state_next = ST_DEC0;
      ST_DEC0:  state_next = ST_DEC1;
      ST_DEC1: begin
        case (dec_class)
          CLS_R:     state_next = ST_EXEC_R;
          CLS_ADDI:  state_next = ST_EXEC_I;
          CLS_LW:    state_next = ST_MEM_ADDR;
          CLS_SW:    state_next = ST_MEM_ADDR;
          CLS_BEQ:   state_next = ST_BRANCH;
          CLS_JMP:   state_next = ST_JUMP;
          CLS_JAL:   state_next = ST_JAL_LINK;
          default:   state_next = ST_HALT;
        endcase
      end
      ST_EXEC_R:   state_next = ST_WB_R;
      ST_EXEC_I:   state_next = ST_WB_I;
      ST_MEM_ADDR: state_next = (dec_class == CLS_SW) ? ST_MEM_WR : ST_MEM_RD;
      ST_MEM_RD:   state_next = ST_MEM_WB;
      ST_HALT:     state_next = ST_HALT;
      ST_JAL_LINK: state_next = ST_JAL_WB;
      default:     state_next = ST_FETCH;
    endcase
  end

  // Outputs decode the state register directly so that FETCH is live on the
  // first cycle after reset, and every output is held at 0 while rst_n is low.
  always_comb begin
    ctl        = '0;
    ctl.alu_op = ALU_ADD;
    case (state_reg)
      ST_FETCH: begin
        ctl.ir_wr = 1'b1; ctl.alu_b_sel = ALUB_FOUR;
        ctl.pc_wr_sel = PCSEL_ALU; ctl.pc_ctrl = 1'b1;
      end
      ST_DEC0, ST_DEC1: begin
        ctl.alu_b_sel = ALUB_IMM; ctl.pc_wr_sel = PCSEL_D;
      end
      ST_EXEC_R: begin
        ctl.alu_a_sel = 1'b1; ctl.alu_b_sel = ALUB_B;
        ctl.alu_op = dec_alu_op; ctl.pc_wr_sel = PCSEL_D;
      end
      ST_EXEC_I, ST_MEM_ADDR: begin
        ctl.alu_a_sel = 1'b1; ctl.alu_b_sel = ALUB_IMM; ctl.pc_wr_sel = PCSEL_D;
      end
      ST_WB_R: begin
        ctl.reg_w_ctl = 1'b1; ctl.reg_data_sel = 1'b1;
        ctl.reg_w_sel = REGW_IR21; ctl.retire = 1'b1;
      end
      ST_WB_I: begin
        ctl.reg_w_ctl = 1'b1; ctl.reg_data_sel = 1'b1;
        ctl.reg_w_sel = REGW_IR26; ctl.retire = 1'b1;
      end
      ST_MEM_RD: begin
        ctl.mem_adr_sel = 1'b1; ctl.pc_wr_sel = PCSEL_D;
      end
      ST_MEM_WB: begin
        ctl.reg_w_ctl = 1'b1; ctl.reg_w_sel = REGW_IR26; ctl.retire = 1'b1;
      end
      ST_MEM_WR: begin
        ctl.mem_adr_sel = 1'b1; ctl.mem_wr_ctl = 1'b1;
        ctl.pc_wr_sel = PCSEL_D; ctl.retire = 1'b1;
      end
      ST_BRANCH: begin
        ctl.alu_a_sel = 1'b1; ctl.alu_b_sel = ALUB_B; ctl.alu_op = ALU_EQ;
        ctl.pc_wr_sel = PCSEL_D; ctl.retire = 1'b1;
      end
      ST_JUMP: begin
        ctl.pc_wr_sel = PCSEL_JUMP; ctl.pc_ctrl = 1'b1; ctl.retire = 1'b1;
      end
      ST_JAL_LINK: begin
        ctl.alu_op = ALU_PASSA; ctl.pc_wr_sel = PCSEL_D;
      end
      ST_JAL_WB: begin
        ctl.reg_w_ctl = 1'b1; ctl.reg_data_sel = 1'b1; ctl.reg_w_sel = REGW_R31;
        ctl.pc_wr_sel = PCSEL_JUMP; ctl.pc_ctrl = 1'b1; ctl.retire = 1'b1;
      end
      ST_HALT: begin
        ctl.alu_op = '0;
        ctl.retire = ~halt_retired_reg;
      end
      default: ;
    endcase
    if (!rst_n) ctl = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg        <= ST_FETCH;
      halted_reg       <= 1'b0;
      illegal_reg      <= 1'b0;
      halt_retired_reg <= 1'b0;
      instr_count_reg  <= '0;
    end else begin
      state_reg <= state_next;
      if (state_next == ST_HALT) halted_reg <= 1'b1;
      if (state_reg == ST_DEC1 && state_next == ST_HALT && dec_illegal)
        illegal_reg <= 1'b1;
      if (state_reg == ST_HALT) halt_retired_reg <= 1'b1;
      if (ctl.retire) instr_count_reg <= instr_count_reg + CNT_WIDTH'(1);
    end
  end

  assign pcWrSel     = ctl.pc_wr_sel;
  assign pcCtrl      = ctl.pc_ctrl;
  assign memAdrSel   = ctl.mem_adr_sel;
  assign memWrCtl    = ctl.mem_wr_ctl;
  assign aluOp       = ctl.alu_op;
  assign aluASel     = ctl.alu_a_sel;
  assign aluBSel     = ctl.alu_b_sel;
  assign regWCtl     = ctl.reg_w_ctl;
  assign regDataSel  = ctl.reg_data_sel;
  assign regWSel     = ctl.reg_w_sel;
  assign irWr        = ctl.ir_wr;
  assign retire      = ctl.retire;
  assign halted      = halted_reg & rst_n;
  assign illegal_op  = illegal_reg & rst_n;
  assign instr_count = instr_count_reg;

endmodule

// File: tb/tb_mc_control_unit.sv
// Cycle-by-cycle vector bench for mc_control_unit: every cycle's full control
// word and instruction count are compared against hand-derived values.
module tb_mc_control_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [5:0]  codop = 6'h00;
  logic [1:0]  pcWrSel, aluBSel, regWSel;
  logic        pcCtrl, memAdrSel, memWrCtl, aluASel, regWCtl, regDataSel;
  logic        irWr, halted, illegal_op, retire;
  logic [3:0]  aluOp;
  logic [31:0] instr_count;

  localparam logic [3:0] A_ADD = 4'd0, A_SLT = 4'd4, A_EQ = 4'd5, A_PASSA = 4'd6;

  mc_control_unit #(.CNT_WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .codop(codop),
    .pcWrSel(pcWrSel), .pcCtrl(pcCtrl), .memAdrSel(memAdrSel),
    .memWrCtl(memWrCtl), .aluOp(aluOp), .aluASel(aluASel), .aluBSel(aluBSel),
    .regWCtl(regWCtl), .regDataSel(regDataSel), .regWSel(regWSel),
    .irWr(irWr), .halted(halted), .illegal_op(illegal_op), .retire(retire),
    .instr_count(instr_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic [5:0]  cod;
    logic [19:0] exp;
  } vec_t;

  vec_t        vecs[$];
  int          errors = 0;
  int          checks = 0;
  logic [31:0] exp_cnt = 0;

  // Layout: pcWrSel,pcCtrl,memAdrSel,memWrCtl,aluOp,aluASel,aluBSel,
  //         regWCtl,regDataSel,regWSel,irWr,halted,illegal_op,retire
  wire [19:0] act = {pcWrSel, pcCtrl, memAdrSel, memWrCtl, aluOp, aluASel,
                     aluBSel, regWCtl, regDataSel, regWSel, irWr, halted,
                     illegal_op, retire};

  function automatic logic [19:0] mk(
    input logic [1:0] pws, input logic pc, input logic ma, input logic mw,
    input logic [3:0] aop, input logic as, input logic [1:0] bs,
    input logic rw, input logic rds, input logic [1:0] rws,
    input logic irw, input logic h, input logic il, input logic rt);
    return {pws, pc, ma, mw, aop, as, bs, rw, rds, rws, irw, h, il, rt};
  endfunction

  task automatic check_word(input string name, input logic [19:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: outputs=%05h required=%05h", name, act, exp);
    end
  endtask

  task automatic check_cnt(input string name, input logic [31:0] exp);
    checks++;
    if (instr_count !== exp) begin
      errors++;
      $display("FAIL %s: instr_count=%0d required=%0d", name, instr_count, exp);
    end
  endtask

  task automatic push(input logic rst, input logic [5:0] cod, input logic [19:0] exp);
    vecs.push_back('{rst: rst, cod: cod, exp: exp});
  endtask

  logic [19:0] e_fetch, e_dec, e_exi, e_wbr, e_wbi, e_mrd, e_mwb, e_mwr;
  logic [19:0] e_br, e_jmp, e_jl, e_jwb, e_h1, e_h, e_h1_ill, e_h_ill;

  initial begin
    e_fetch  = mk(2'b00, 1, 0, 0, A_ADD,   0, 2'b01, 0, 0, 2'b00, 1, 0, 0, 0);
    e_dec    = mk(2'b01, 0, 0, 0, A_ADD,   0, 2'b10, 0, 0, 2'b00, 0, 0, 0, 0);
    e_exi    = mk(2'b01, 0, 0, 0, A_ADD,   1, 2'b10, 0, 0, 2'b00, 0, 0, 0, 0);
    e_wbr    = mk(2'b00, 0, 0, 0, A_ADD,   0, 2'b00, 1, 1, 2'b00, 0, 0, 0, 1);
    e_wbi    = mk(2'b00, 0, 0, 0, A_ADD,   0, 2'b00, 1, 1, 2'b01, 0, 0, 0, 1);
    e_mrd    = mk(2'b01, 0, 1, 0, A_ADD,   0, 2'b00, 0, 0, 2'b00, 0, 0, 0, 0);
    e_mwb    = mk(2'b00, 0, 0, 0, A_ADD,   0, 2'b00, 1, 0, 2'b01, 0, 0, 0, 1);
    e_mwr    = mk(2'b01, 0, 1, 1, A_ADD,   0, 2'b00, 0, 0, 2'b00, 0, 0, 0, 1);
    e_br     = mk(2'b01, 0, 0, 0, A_EQ,    1, 2'b00, 0, 0, 2'b00, 0, 0, 0, 1);
    e_jmp    = mk(2'b10, 1, 0, 0, A_ADD,   0, 2'b00, 0, 0, 2'b00, 0, 0, 0, 1);
    e_jl     = mk(2'b01, 0, 0, 0, A_PASSA, 0, 2'b00, 0, 0, 2'b00, 0, 0, 0, 0);
    e_jwb    = mk(2'b10, 1, 0, 0, A_ADD,   0, 2'b00, 1, 1, 2'b10, 0, 0, 0, 1);
    e_h1     = 20'h00004 | 20'h00001;
    e_h      = 20'h00004;
    e_h1_ill = 20'h00007;
    e_h_ill  = 20'h00006;

    // ADD, SLT, LW, SW, BEQ, JMP, ADDI, JAL, then HALT held for 20 cycles
    push(0, 6'h01, 20'h0);
    push(1, 6'h01, e_fetch); push(1, 6'h01, e_dec); push(1, 6'h01, e_dec);
    push(1, 6'h01, mk(2'b01, 0, 0, 0, A_ADD, 1, 2'b00, 0, 0, 2'b00, 0, 0, 0, 0));
    push(1, 6'h01, e_wbr);
    push(1, 6'h05, e_fetch); push(1, 6'h05, e_dec); push(1, 6'h05, e_dec);
    push(1, 6'h05, mk(2'b01, 0, 0, 0, A_SLT, 1, 2'b00, 0, 0, 2'b00, 0, 0, 0, 0));
    push(1, 6'h05, e_wbr);
    push(1, 6'h20, e_fetch); push(1, 6'h20, e_dec); push(1, 6'h20, e_dec);
    push(1, 6'h20, e_exi); push(1, 6'h20, e_mrd); push(1, 6'h20, e_mwb);
    push(1, 6'h21, e_fetch); push(1, 6'h21, e_dec); push(1, 6'h21, e_dec);
    push(1, 6'h21, e_exi); push(1, 6'h21, e_mwr);
    push(1, 6'h30, e_fetch); push(1, 6'h30, e_dec); push(1, 6'h30, e_dec);
    push(1, 6'h30, e_br);
    push(1, 6'h31, e_fetch); push(1, 6'h31, e_dec); push(1, 6'h31, e_dec);
    push(1, 6'h31, e_jmp);
    push(1, 6'h11, e_fetch); push(1, 6'h11, e_dec); push(1, 6'h11, e_dec);
    push(1, 6'h11, e_exi); push(1, 6'h11, e_wbi);
    push(1, 6'h32, e_fetch); push(1, 6'h32, e_dec); push(1, 6'h32, e_dec);
    push(1, 6'h32, e_jl); push(1, 6'h32, e_jwb);
    push(1, 6'h3F, e_fetch); push(1, 6'h3F, e_dec); push(1, 6'h3F, e_dec);
    push(1, 6'h3F, e_h1);
    for (int i = 0; i < 20; i++) push(1, 6'h01, e_h);
    // Reset out of HALT, then an unknown opcode
    push(0, 6'h2A, 20'h0);
    push(1, 6'h2A, e_fetch); push(1, 6'h2A, e_dec); push(1, 6'h2A, e_dec);
    push(1, 6'h2A, e_h1_ill); push(1, 6'h2A, e_h_ill); push(1, 6'h01, e_h_ill);

    foreach (vecs[i]) begin
      @(posedge clk);
      #1;
      rst_n = vecs[i].rst;
      codop = vecs[i].cod;
      if (!vecs[i].rst) exp_cnt = 0;
      @(negedge clk);
      check_word($sformatf("vec%0d", i), vecs[i].exp);
      check_cnt($sformatf("vec%0d_cnt", i), exp_cnt);
      $display("vec %0d rst_n=%0b codop=%02h outputs=%05h count=%0d",
               i, vecs[i].rst, vecs[i].cod, act, instr_count);
      if (vecs[i].exp[0]) exp_cnt++;
    end

    // Reset asserted during MEM_WR of a store must drop memWrCtl at once
    @(posedge clk); #1 rst_n = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1; codop = 6'h21;
    repeat (4) @(posedge clk);
    #2;
    check_word("sw_mem_wr", e_mwr);
    $display("mid-store reset: before reset outputs=%05h", act);
    rst_n = 1'b0;
    #1;
    check_word("sw_reset_async", 20'h0);
    $display("mid-store reset: during reset outputs=%05h", act);
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    check_word("post_reset_fetch", e_fetch);
    check_cnt("post_reset_cnt", 32'd0);
    $display("mid-store reset: after release outputs=%05h count=%0d", act, instr_count);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
